pwm_generator: RTL
==================

Name: pwm_generator

Overview:
Downstream stage of the angle-to-PWM controller. It consumes pwm_ratio/pwm_update/pwm_enable/pwm_direction and drives the physical motor PWM pin and direction pin. A new ratio is buffered and applied only at a PWM period boundary, so no glitched pulses are produced. Each application is acknowledged with a one-cycle pwm_done pulse, so the upstream profile steps in whole PWM periods.

Parameters:
CLK_DIV, 4, clocks per PWM count tick (≥1); PWM period = 255*CLK_DIV clocks
RESET_RATIO, 128, active/shadow ratio after reset (neutral/stop)
DEADBAND_PERIODS, 2, full periods of forced-low output on direction change (used only with PWM_DEADBAND_EN)

Ports:
clock  in  1  main clock
reset_n  in  1  asynchronous active-low reset
pwm_enable  in  1  level; 0 forces output low and halts the period counter
pwm_update  in  1  level request to apply pwm_ratio/pwm_direction
pwm_ratio  in  8  requested high time out of 255
pwm_direction  in  1  requested motor direction
pwm_done  out  1  one-cycle pulse: buffered ratio has been applied
pwm_out  out  1  PWM waveform to the motor driver
pwm_dir_out  out  1  applied direction to the motor driver

Behaviour:
- Reset (async, any time incl. mid-period): pwm_out=0, pwm_done=0, pwm_dir_out=0, presc=0, cnt=0, active_ratio=shadow_ratio=RESET_RATIO, pending=0.
- Prescaler presc counts 0..CLK_DIV-1. tick=1 when presc==CLK_DIV-1 and pwm_enable=1. cnt (8b) increments on tick and wraps 254->0. boundary = tick & cnt==254.
- Output: pwm_out <= pwm_enable & (cnt < active_ratio), registered, 1-cycle latency. Ratio 0 -> constant low; 255 -> constant high.
- Capture: in any cycle with pwm_update=1 and pwm_done=0: shadow_ratio<=pwm_ratio, shadow_dir<=pwm_direction, pending<=1. Later captures before application overwrite (last wins). pwm_update is ignored while pwm_done=1, so the upstream's one-cycle-late deassert does not re-arm.
- Apply: when pending and (boundary or pwm_enable=0): active_ratio<=shadow_ratio, pwm_dir_out<=shadow_dir, pending<=0, pwm_done<=1 next cycle for exactly 1 cycle. Capture and apply in the same cycle: the apply uses the newly captured value directly; pending ends at 0.
- Disabled: presc and cnt held at 0, pwm_out=0; pending updates apply immediately (done pulse the cycle after) so the upstream never stalls.
- Re-enable: the period starts at cnt=0.
- Update with an unchanged value is still applied and acknowledged.
- Worst-case ack latency while enabled: 255*CLK_DIV+1 clocks.

Optional Feature:
PWM_DEADBAND_EN: when an apply changes pwm_dir_out, pwm_out is forced low for DEADBAND_PERIODS full periods starting at that boundary. pwm_dir_out switches at the start of the deadband. The new ratio takes effect only after the deadband ends. Further applies (and done pulses) are deferred until the deadband ends. A deadband counter resets to 0 on reset_n and on pwm_enable=0, and disable aborts the deadband.
Without the macro: direction and ratio change together at the boundary, with no forced-low interval.

Decomposition:
- Shared package/constants file: PWM_CNT_MAX=8'd254, PWM_NEUTRAL=8'd128, and the ratio width (8).
- Sub-module pwm_prescaler (CLK_DIV parameter; clock, reset_n, enable in; tick out) is natural and reusable.
- Capture/apply logic, counter and compare stay in pwm_generator.

Test Plan:
- Reset then enable=1, no update, CLK_DIV=4 -> pwm_out high for 512 clocks and low for 508 per 1020-clock period; pwm_done never asserts.
- Mid-period, pulse pwm_update with ratio=200 -> no waveform change until the cnt 254->0 wrap; pwm_done high for exactly 1 cycle after the wrap; next period has 800 clocks high.
- Hold pwm_update high and drop it the cycle after pwm_done, mimicking the upstream -> exactly one done per period, no double apply.
- Send ratio 0, then 255 -> constant low for the whole period, then constant high, with no single-count glitch.
- enable=0 with update ratio=64 -> pwm_out low, done one cycle after capture; on re-enable, high time is 256 clocks from cnt=0.
- Assert reset_n low mid-period with pending=1 -> all outputs 0 immediately; after release, ratio=128 and no done pulse. With PWM_DEADBAND_EN: flip direction -> pwm_out low for 2 periods, then the new ratio is applied.

Source files
------------

// File: rtl/pwm_generator_pkg.sv
// Shared constants and types for the PWM output stage.
package pwm_generator_pkg;

    localparam int unsigned        RATIO_W     = 8;
    localparam logic [RATIO_W-1:0] PWM_CNT_MAX = 8'd254;
    localparam logic [RATIO_W-1:0] PWM_NEUTRAL = 8'd128;

    typedef enum logic {
        DB_IDLE,
        DB_HOLD
    } db_state_e;

endpackage

// File: rtl/pwm_generator_if.sv
// Ratio/direction request bus and motor-pin outputs of the PWM stage.
interface pwm_generator_if
    import pwm_generator_pkg::*;
;
    logic               pwm_enable;
    logic               pwm_update;
    logic [RATIO_W-1:0] pwm_ratio;
    logic               pwm_direction;
    logic               pwm_done;
    logic               pwm_out;
    logic               pwm_dir_out;

    modport master (
        output pwm_enable, pwm_update, pwm_ratio, pwm_direction,
        input  pwm_done, pwm_out, pwm_dir_out
    );

    modport slave (
        input  pwm_enable, pwm_update, pwm_ratio, pwm_direction,
        output pwm_done, pwm_out, pwm_dir_out
    );
endinterface

// File: rtl/pwm_generator_prescaler.sv
// Clock divider producing one PWM count tick every CLK_DIV enabled clocks.
module pwm_prescaler #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_presc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (!enable || (r_presc == PRESC_LAST)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign tick = enable && (r_presc == PRESC_LAST);

endmodule

// File: rtl/pwm_generator.sv
// PWM output stage: buffers ratio/direction requests and applies them at period boundaries.
// Optional build macro PWM_DEADBAND_EN adds a forced-low interval on direction reversal.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int unsigned        CLK_DIV          = 4,
    parameter logic [RATIO_W-1:0] RESET_RATIO      = PWM_NEUTRAL,
    parameter int unsigned        DEADBAND_PERIODS = 2
) (
    input logic            clock,
    input logic            reset_n,
    pwm_generator_if.slave bus
);
    logic               w_tick;
    logic               w_boundary;
    logic               w_capture;
    logic               w_pending;
    logic               w_apply;
    logic               w_commit;
    logic               w_force_low;
    logic               w_sh_dir;
    logic [RATIO_W-1:0] w_sh_ratio;

    logic [RATIO_W-1:0] r_cnt;
    logic [RATIO_W-1:0] r_active;
    logic [RATIO_W-1:0] r_shadow;
    logic               r_shdir;
    logic               r_pending;
    logic               r_done;
    logic               r_out;
    logic               r_dir;

    pwm_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_presc (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (bus.pwm_enable),
        .tick   (w_tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!bus.pwm_enable) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= (r_cnt == PWM_CNT_MAX) ? '0 : r_cnt + 1'b1;
        end
    end

    assign w_boundary = w_tick && (r_cnt == PWM_CNT_MAX);

    // Requests are ignored during the done pulse so a late upstream deassert cannot re-arm.
    assign w_capture  = bus.pwm_update && !r_done;
    assign w_sh_ratio = w_capture ? bus.pwm_ratio : r_shadow;
    assign w_sh_dir   = w_capture ? bus.pwm_direction : r_shdir;
    assign w_pending  = w_capture || r_pending;

`ifdef PWM_DEADBAND_EN
    localparam int unsigned DB_W = (DEADBAND_PERIODS > 1) ? $clog2(DEADBAND_PERIODS) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEADBAND_PERIODS - 1);

    db_state_e       r_db_state, w_db_state_nxt;
    logic [DB_W-1:0] r_db_cnt, w_db_cnt_nxt;
    logic            w_db_last;
    logic            w_start_db;

    assign w_db_last  = w_boundary && (r_db_cnt == DB_LAST);
    assign w_apply    = w_pending && (w_boundary || !bus.pwm_enable)
                     && ((r_db_state == DB_IDLE) || w_db_last || !bus.pwm_enable);
    // A reversal while running switches direction now but holds the ratio until the deadband ends.
    assign w_start_db = w_apply && bus.pwm_enable && (w_sh_dir != r_dir);
    assign w_commit   = w_apply && !w_start_db;
    assign w_force_low = (r_db_state == DB_HOLD);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_db_state <= DB_IDLE;
            r_db_cnt   <= '0;
        end else begin
            r_db_state <= w_db_state_nxt;
            r_db_cnt   <= w_db_cnt_nxt;
        end
    end

    always_comb begin
        w_db_state_nxt = r_db_state;
        w_db_cnt_nxt   = r_db_cnt;
        if (!bus.pwm_enable) begin
            w_db_state_nxt = DB_IDLE;
            w_db_cnt_nxt   = '0;
        end else begin
            case (r_db_state)
                DB_IDLE: begin
                    if (w_start_db) begin
                        w_db_state_nxt = DB_HOLD;
                        w_db_cnt_nxt   = '0;
                    end
                end
                DB_HOLD: begin
                    if (w_db_last) begin
                        w_db_state_nxt = w_start_db ? DB_HOLD : DB_IDLE;
                        w_db_cnt_nxt   = '0;
                    end else if (w_boundary) begin
                        w_db_cnt_nxt = r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    w_db_state_nxt = DB_IDLE;
                    w_db_cnt_nxt   = '0;
                end
            endcase
        end
    end
`else
    logic w_unused_db;

    assign w_apply     = w_pending && (w_boundary || !bus.pwm_enable);
    assign w_commit    = w_apply;
    assign w_force_low = 1'b0;
    assign w_unused_db = (DEADBAND_PERIODS == 0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active  <= RESET_RATIO;
            r_shadow  <= RESET_RATIO;
            r_shdir   <= 1'b0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_out     <= 1'b0;
            r_dir     <= 1'b0;
        end else begin
            r_shadow  <= w_sh_ratio;
            r_shdir   <= w_sh_dir;
            r_out     <= bus.pwm_enable && !w_force_low && (r_cnt < r_active);
            r_done    <= w_commit;
            r_pending <= w_pending && !w_commit;
            if (w_commit) begin
                r_active <= w_sh_ratio;
            end
            if (w_apply) begin
                r_dir <= w_sh_dir;
            end
        end
    end

    assign bus.pwm_done    = r_done;
    assign bus.pwm_out     = r_out;
    assign bus.pwm_dir_out = r_dir;

endmodule
